// File: rtl/new_means_seq_div_unit.sv
// new_means_seq_div_unit: snapshots the per-centroid accumulators and member
// counts, computes each new centroid as a fixed-point mean
// (accum * 2^FRAC_W / cnt) with one shared bit-serial restoring divider, and
// streams the centroids out in index order.
//
// Output handshake: a result is offered while out_valid is high; out_cent_idx,
// new_centroid, divide_by_0 and saturated are held stable until a cycle with
// out_valid && out_ready, and the transfer happens on that clock edge.
// out_ready is only sampled by the state register, so no output depends
// combinationally on it.
module new_means_seq_div_unit #(
   parameter  int CENT_NUM = 8,
   parameter  int DIM      = 7,
   parameter  int ACC_W    = 22,
   parameter  int CNT_W    = 10,
   parameter  int CORD_W   = 13,
   parameter  int FRAC_W   = 0,
   localparam int QW       = ACC_W + FRAC_W,
   localparam int IDX_W    = $clog2(CENT_NUM)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   input  logic [CENT_NUM*DIM*ACC_W-1:0] accum_flat,
   input  logic [CENT_NUM*CNT_W-1:0]     cnt_flat,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IDX_W-1:0]              out_cent_idx,
   output logic [DIM*CORD_W-1:0]         new_centroid,
   output logic                          divide_by_0,
   output logic                          saturated,
   output logic                          done
);

   localparam int D_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int B_W = (QW > 1) ? $clog2(QW) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CENT, S_DIV, S_OUT, S_FIN} state_t;

   state_t                        state_q, state_d;
   logic [CENT_NUM*DIM*ACC_W-1:0] snap_acc_q, snap_acc_d;
   logic [CENT_NUM*CNT_W-1:0]     snap_cnt_q, snap_cnt_d;
   logic [IDX_W-1:0]              c_q, c_d;
   logic [D_W-1:0]                d_q, d_d;
   logic [B_W-1:0]                bit_q, bit_d;
   logic [QW-1:0]                 quo_q, quo_d;
   logic [CNT_W-1:0]              rem_q, rem_d;
   logic [DIM*CORD_W-1:0]         res_q, res_d;
   logic                          dz_q, dz_d;
   logic                          sat_q, sat_d;

   logic [CNT_W-1:0]              cnt_sel;
   logic [D_W-1:0]                load_d;
   logic [ACC_W-1:0]              acc_sel;
   logic [QW-1:0]                 dividend;
   logic [CNT_W:0]                rem_sh;
   logic [CNT_W:0]                sub;
   logic                          ge;
   logic [CNT_W-1:0]              rem_nx;
   logic [QW-1:0]                 quo_nx;
   logic [QW+CORD_W-1:0]          q_ext;
   logic                          q_sat;
   logic [CORD_W-1:0]             coord;

   // Divider datapath: operand selection from the snapshot and one restoring step.
   always_comb begin
      cnt_sel  = snap_cnt_q[int'(c_q)*CNT_W +: CNT_W];
      // In DIV the next coordinate is loaded on the same edge as the last bit.
      load_d   = (state_q == S_DIV) ? d_q + 1'b1 : '0;
      acc_sel  = snap_acc_q[(int'(c_q)*DIM + int'(load_d))*ACC_W +: ACC_W];
      dividend = QW'(acc_sel) << FRAC_W;
      rem_sh   = {rem_q, quo_q[QW-1]};
      // A set top bit means rem_sh already exceeds any CNT_W-bit divisor.
      sub      = {1'b0, rem_sh[CNT_W-1:0]} - {1'b0, cnt_sel};
      ge       = rem_sh[CNT_W] | ~sub[CNT_W];
      rem_nx   = ge ? sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      quo_nx   = {quo_q[QW-2:0], ge};
      q_ext    = {{CORD_W{1'b0}}, quo_nx};
      q_sat    = |q_ext[QW+CORD_W-1:CORD_W];
      coord    = q_sat ? '1 : q_ext[CORD_W-1:0];
   end

   // Next-state and register update logic for the pass sequencer.
   always_comb begin
      state_d    = state_q;
      snap_acc_d = snap_acc_q;
      snap_cnt_d = snap_cnt_q;
      c_d        = c_q;
      d_d        = d_q;
      bit_d      = bit_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      res_d      = res_q;
      dz_d       = dz_q;
      sat_d      = sat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_acc_d = accum_flat;
               snap_cnt_d = cnt_flat;
               c_d        = '0;
               state_d    = S_CENT;
            end
         end
         S_CENT: begin
            dz_d  = 1'b0;
            sat_d = 1'b0;
            if (cnt_sel == '0) begin
               res_d   = '0;
               dz_d    = 1'b1;
               state_d = S_OUT;
            end else begin
               d_d     = '0;
               bit_d   = '0;
               quo_d   = dividend;
               rem_d   = '0;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            bit_d = bit_q + 1'b1;
            quo_d = quo_nx;
            rem_d = rem_nx;
            if (bit_q == B_W'(QW-1)) begin
               res_d[int'(d_q)*CORD_W +: CORD_W] = coord;
               if (q_sat) begin
                  sat_d = 1'b1;
               end
               if (d_q == D_W'(DIM-1)) begin
                  state_d = S_OUT;
               end else begin
                  d_d   = d_q + 1'b1;
                  bit_d = '0;
                  quo_d = dividend;
                  rem_d = '0;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (c_q == IDX_W'(CENT_NUM-1)) begin
                  state_d = S_FIN;
               end else begin
                  c_d     = c_q + 1'b1;
                  state_d = S_CENT;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any pass in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         snap_acc_q <= '0;
         snap_cnt_q <= '0;
         c_q        <= '0;
         d_q        <= '0;
         bit_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         res_q      <= '0;
         dz_q       <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_acc_q <= snap_acc_d;
         snap_cnt_q <= snap_cnt_d;
         c_q        <= c_d;
         d_q        <= d_d;
         bit_q      <= bit_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         res_q      <= res_d;
         dz_q       <= dz_d;
         sat_q      <= sat_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign out_valid    = (state_q == S_OUT);
   assign done         = (state_q == S_FIN);
   assign out_cent_idx = c_q;
   assign new_centroid = res_q;
   assign divide_by_0  = dz_q;
   assign saturated    = sat_q;

endmodule

// File: tb/tb_new_means_seq_div_unit.sv
// Bench for new_means_seq_div_unit: two instances (FRAC_W=0 and FRAC_W=4) share
// stimulus; each has its own expected-result and expected-latency queues.
module tb_new_means_seq_div_unit;
   localparam int CENT_NUM = 8;
   localparam int DIM      = 7;
   localparam int ACC_W    = 22;
   localparam int CNT_W    = 10;
   localparam int CORD_W   = 13;
   localparam int IDX_W    = 3;
   localparam int EW       = IDX_W + 2 + DIM*CORD_W;
   localparam int NI       = 2;
   localparam int ACC_MAX  = (1 << ACC_W) - 1;
   localparam int CORD_MAX = (1 << CORD_W) - 1;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          start = 1'b0;
   logic                          out_ready = 1'b1;
   logic [CENT_NUM*DIM*ACC_W-1:0] accum_flat = '0;
   logic [CENT_NUM*CNT_W-1:0]     cnt_flat = '0;
   logic                          busy [NI];
   logic                          ov   [NI];
   logic                          done [NI];
   logic                          odz  [NI];
   logic                          osat [NI];
   logic [IDX_W-1:0]              oidx [NI];
   logic [DIM*CORD_W-1:0]         ocent[NI];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [EW-1:0] exp_q[NI][$];
   int lat_q[NI][$];
   int ref_edge[NI];
   int done_at[NI];
   int n_done[NI] = '{0, 0};
   logic ov_prev[NI];

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   new_means_seq_div_unit #(.FRAC_W(0)) u_dut_f0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy[0]),
      .accum_flat(accum_flat), .cnt_flat(cnt_flat),
      .out_valid(ov[0]), .out_ready(out_ready), .out_cent_idx(oidx[0]),
      .new_centroid(ocent[0]), .divide_by_0(odz[0]), .saturated(osat[0]),
      .done(done[0])
   );

   new_means_seq_div_unit #(.FRAC_W(4)) u_dut_f4 (
      .clk(clk), .rst(rst), .start(start), .busy(busy[1]),
      .accum_flat(accum_flat), .cnt_flat(cnt_flat),
      .out_valid(ov[1]), .out_ready(out_ready), .out_cent_idx(oidx[1]),
      .new_centroid(ocent[1]), .divide_by_0(odz[1]), .saturated(osat[1]),
      .done(done[1])
   );

   function automatic int frac_of(input int i);
      return (i == 0) ? 0 : 4;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference mean: plain integer division of the scaled accumulator.
   function automatic logic [EW-1:0] model(input int frac, input int c);
      logic [CNT_W-1:0]      n;
      logic [DIM*CORD_W-1:0] cent;
      logic                  sat;
      longint unsigned       a, q;
      n    = cnt_flat[c*CNT_W +: CNT_W];
      cent = '0;
      sat  = 1'b0;
      if (n != 0) begin
         for (int d = 0; d < DIM; d++) begin
            a = 64'(accum_flat[(c*DIM+d)*ACC_W +: ACC_W]);
            q = (a << frac) / 64'(n);
            if (q > 64'(CORD_MAX)) begin
               cent[d*CORD_W +: CORD_W] = '1;
               sat = 1'b1;
            end else begin
               cent[d*CORD_W +: CORD_W] = q[CORD_W-1:0];
            end
         end
      end
      return {IDX_W'(c), (n == 0), sat, cent};
   endfunction

   task automatic set_acc(input int c, input int d, input int v);
      accum_flat[(c*DIM+d)*ACC_W +: ACC_W] = ACC_W'(v);
   endtask

   task automatic set_cnt(input int c, input int v);
      cnt_flat[c*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   task automatic setup_random();
      int unsigned n, lim;
      for (int c = 0; c < CENT_NUM; c++) begin
         n = (c != 0 && $urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 1023);
         set_cnt(c, int'(n));
         lim = (n == 0) ? ACC_MAX : n * 700;
         for (int d = 0; d < DIM; d++) set_acc(c, d, int'($urandom_range(0, lim)));
      end
   endtask

   task automatic setup_directed();
      setup_random();
      set_cnt(0, 8);    set_acc(0, 0, 100);
      set_cnt(1, 3);    set_acc(1, 0, 10);
      set_cnt(2, 1023); set_acc(2, 0, ACC_MAX);
      set_cnt(3, 0);
      set_cnt(4, 17);
      set_cnt(5, 1);    set_acc(5, 0, 21); set_acc(5, 1, 1000); set_acc(5, 2, 5);
      set_cnt(6, 1);    set_acc(6, 0, ACC_MAX);
      set_cnt(7, 500);
   endtask

   // Driver: pulse start, record expectations from the inputs being snapshotted.
   task automatic start_pass();
      int n;
      @(posedge clk); #1;
      start = 1'b1;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < CENT_NUM; c++) begin
            n = int'(cnt_flat[c*CNT_W +: CNT_W]);
            exp_q[i].push_back(model(frac_of(i), c));
            lat_q[i].push_back((n == 0) ? 1 : 1 + DIM*(ACC_W + frac_of(i)));
         end
         ref_edge[i] = cyc + 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("busy_on_start", busy[i], 1'b1);
   endtask

   // Driver: run until both instances finish; optional 50-cycle stall on centroid 1.
   task automatic run_pass(input bit bp, input int target);
      int held[NI];
      int k;
      for (int i = 0; i < NI; i++) held[i] = 0;
      k = 0;
      while (!(n_done[0] >= target && n_done[1] >= target) && k < 4000) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (bp) begin
            for (int i = 0; i < NI; i++) begin
               if (ov[i] && oidx[i] == 3'd1 && held[i] < 50) begin
                  out_ready = 1'b0;
                  held[i]++;
               end
            end
         end
         k++;
      end
      out_ready = 1'b1;
      check("pass_complete", n_done[0] + n_done[1], 2*target);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            exp_q[i].delete();
            lat_q[i].delete();
            done_at[i] = -10;
            ov_prev[i] = 1'b0;
         end else begin
            if (ov[i] && !ov_prev[i]) begin
               if (lat_q[i].size() == 0) check("unexpected_valid", ov[i], 1'b0);
               else check("latency", 128'(cyc - ref_edge[i]), 128'(lat_q[i].pop_front()));
            end
            if (ov[i]) begin
               if (exp_q[i].size() == 0) begin
                  check("unexpected_output", ov[i], 1'b0);
               end else begin
                  e = exp_q[i][0];
                  check("result", {oidx[i], odz[i], osat[i], ocent[i]}, e);
                  if (out_ready) begin
                     if (e[EW-1 -: IDX_W] == IDX_W'(CENT_NUM-1)) done_at[i] = cyc + 1;
                     void'(exp_q[i].pop_front());
                     ref_edge[i] = cyc + 1;
                  end
               end
            end
            if (done[i] || cyc == done_at[i]) begin
               check("done_pulse", done[i], cyc == done_at[i]);
               if (done[i]) n_done[i]++;
            end
            if (cyc == done_at[i] + 1) check("busy_after_done", busy[i], 1'b0);
            ov_prev[i] = ov[i];
         end
      end
   end

   // Main sequence and final report
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++)
         check("reset_outputs", {busy[i], ov[i], done[i], odz[i], osat[i], oidx[i], ocent[i]}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed values, zero-count centroid, saturation, out_ready held high
      setup_directed();
      start_pass();
      run_pass(1'b0, 1);

      // random values with backpressure on centroid 1
      setup_random();
      start_pass();
      run_pass(1'b1, 2);

      // start while busy with changed inputs must not disturb the snapshot
      setup_random();
      start_pass();
      repeat (40) @(posedge clk);
      #1;
      start = 1'b1;
      setup_random();
      @(posedge clk); #1;
      start = 1'b0;
      run_pass(1'b0, 3);

      // reset in the middle of a pass
      setup_random();
      start_pass();
      repeat (60) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++)
         check("reset_mid_pass", {busy[i], ov[i], done[i], odz[i], osat[i], oidx[i], ocent[i]}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("idle_after_reset", {busy[i], ov[i]}, 2'b00);

      // fresh pass after the abort
      setup_random();
      start_pass();
      run_pass(1'b0, 4);

      for (int i = 0; i < NI; i++) begin
         check("queue_empty", exp_q[i].size(), 0);
         check("done_count", n_done[i], 4);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
